// File: rtl/cmap_pkg.sv
// Shared defaults, FSM encoding and RGB slot ordering for the colormap controller.
package cmap_pkg;

  localparam int unsigned PW_DEF = 8;
  localparam int unsigned CW_DEF = 8;

  // Table entries are packed {r,g,b} with r in the MSBs; slot index counts CW-wide fields from the LSB.
  localparam int unsigned R_SLOT = 2;
  localparam int unsigned G_SLOT = 1;
  localparam int unsigned B_SLOT = 0;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } state_t;

endpackage

// File: rtl/cmap_bank_ram.sv
// Two-bank colormap RAM: address {bank,index}, per-bank write mask, registered read with enable.
module cmap_bank_ram #(
  parameter int unsigned PW = 8,
  parameter int unsigned DW = 24
) (
  input  logic          i_clk,
  input  logic [1:0]    i_we,
  input  logic [PW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [PW:0]   i_raddr,
  output logic [DW-1:0] o_rdata
);

  localparam int unsigned DEPTH = 2 ** (PW + 1);

  logic [DW-1:0] r_mem [DEPTH];

  // Masked writes into either bank, plus the registered read port.
  always_ff @(posedge i_clk) begin
    if (i_we[0]) r_mem[{1'b0, i_waddr}] <= i_wdata;
    if (i_we[1]) r_mem[{1'b1, i_waddr}] <= i_wdata;
    if (i_re)    o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/cmap_ctrl.sv
// Double-buffered false-color map: grayscale fill after reset, back-bank writes, swap on frame start.
module cmap_ctrl
  import cmap_pkg::*;
#(
  parameter int unsigned PW = PW_DEF,
  parameter int unsigned CW = CW_DEF
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_wr,
  input  logic [PW-1:0]   i_waddr,
  input  logic [3*CW-1:0] i_wdata,
  input  logic            i_commit,
  output logic            o_werr,
  output logic            o_busy,
  output logic            o_pending,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [PW-1:0]   i_pixel,
  input  logic            i_sof,
  input  logic            i_last,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [CW-1:0]   o_r,
  output logic [CW-1:0]   o_g,
  output logic [CW-1:0]   o_b,
  output logic            o_sof,
  output logic            o_last
);

  localparam int unsigned   DW       = 3 * CW;
  localparam logic [PW-1:0] CNT_LAST = '1;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [PW-1:0]   r_cnt;
  logic            r_active;
  logic            r_s1_valid;
  logic            r_s1_sof;
  logic            r_s1_last;

  logic            w_ce;
  logic            w_acc;
  logic            w_swap;
  logic            w_rbank;
  logic [1:0]      w_we;
  logic [PW-1:0]   w_waddr;
  logic [DW-1:0]   w_wdata;
  logic [CW-1:0]   w_gray;
  logic [DW-1:0]   w_rdata;

  // Pipeline advance and per-beat bank selection; a sof beat in PEND already reads the new bank.
  assign w_ce    = (r_state != ST_INIT) && (!o_valid || i_ready);
  assign w_acc   = w_ce && i_valid;
  assign w_swap  = (r_state == ST_PEND) && w_acc && i_sof;
  assign w_rbank = r_active ^ w_swap;
  assign w_gray  = CW'(r_cnt);

  assign o_ready   = w_ce;
  assign o_busy    = (r_state == ST_INIT);
  assign o_pending = (r_state == ST_PEND);

  // Next state and write-port steering: INIT fills both banks, RUN writes the back bank only.
  always_comb begin
    w_state_nxt = r_state;
    w_we        = 2'b00;
    w_waddr     = i_waddr;
    w_wdata     = i_wdata;
    case (r_state)
      ST_INIT: begin
        w_we    = 2'b11;
        w_waddr = r_cnt;
        w_wdata = {w_gray, w_gray, w_gray};
        if (r_cnt == CNT_LAST) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (i_wr) w_we = r_active ? 2'b01 : 2'b10;
        if (i_commit) w_state_nxt = ST_PEND;
      end
      ST_PEND: begin
        if (w_swap) w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_INIT;
    endcase
    if (i_reset) w_we = 2'b00;
  end

  cmap_bank_ram #(
    .PW (PW),
    .DW (DW)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_re    (w_ce),
    .i_raddr ({w_rbank, i_pixel}),
    .o_rdata (w_rdata)
  );

  // Control state, bank pointer and write-error pulse.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= ST_INIT;
      r_cnt    <= '0;
      r_active <= 1'b0;
      o_werr   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_INIT) r_cnt <= r_cnt + PW'(1);
      if (w_swap) r_active <= ~r_active;
      o_werr <= i_wr && (r_state != ST_RUN);
    end
  end

  // Two-stage pixel pipeline: stage 1 tracks the RAM read, stage 2 is the output register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_s1_valid <= 1'b0;
      r_s1_sof   <= 1'b0;
      r_s1_last  <= 1'b0;
      o_valid    <= 1'b0;
      o_r        <= '0;
      o_g        <= '0;
      o_b        <= '0;
      o_sof      <= 1'b0;
      o_last     <= 1'b0;
    end else if (w_ce) begin
      r_s1_valid <= i_valid;
      r_s1_sof   <= i_sof;
      r_s1_last  <= i_last;
      o_valid    <= r_s1_valid;
      if (r_s1_valid) begin
        o_r    <= w_rdata[R_SLOT*CW +: CW];
        o_g    <= w_rdata[G_SLOT*CW +: CW];
        o_b    <= w_rdata[B_SLOT*CW +: CW];
        o_sof  <= r_s1_sof;
        o_last <= r_s1_last;
      end
    end
  end

endmodule

// File: tb/tb_cmap_ctrl.sv
// Directed bench for cmap_ctrl with a reference colormap model and an output scoreboard.
module tb_cmap_ctrl;

  logic        i_clk = 1'b0;
  logic        i_reset, i_wr, i_commit, i_valid, i_sof, i_last, i_ready;
  logic [7:0]  i_waddr, i_pixel;
  logic [23:0] i_wdata;
  logic        o_werr, o_busy, o_pending, o_ready, o_valid, o_sof, o_last;
  logic [7:0]  o_r, o_g, o_b;

  always #5 i_clk = ~i_clk;

  cmap_ctrl dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_wr(i_wr), .i_waddr(i_waddr), .i_wdata(i_wdata),
    .i_commit(i_commit), .o_werr(o_werr), .o_busy(o_busy), .o_pending(o_pending),
    .i_valid(i_valid), .o_ready(o_ready), .i_pixel(i_pixel), .i_sof(i_sof), .i_last(i_last),
    .o_valid(o_valid), .i_ready(i_ready), .o_r(o_r), .o_g(o_g), .o_b(o_b),
    .o_sof(o_sof), .o_last(o_last)
  );

  typedef struct packed {
    logic [23:0] rgb;
    logic        sof;
    logic        last;
  } beat_t;

  int          checks = 0;
  int          errors = 0;
  beat_t       q[$];
  logic [23:0] m_bank [2][256];
  int          m_state;
  int          m_cnt;
  logic        m_act, m_werr, m_known;
  logic        hold_pend;
  beat_t       hold_val;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Negedge: compare outputs against the scoreboard, then advance the reference model.
  task automatic sample();
    beat_t cur, exp_b;
    int    old;
    logic  swap, sel;
    cur.rgb = {o_r, o_g, o_b};
    cur.sof = o_sof;
    cur.last = o_last;
    if (m_known) begin
      chk("busy", 32'(o_busy), 32'(m_state == 0));
      chk("pending", 32'(o_pending), 32'(m_state == 2));
      chk("werr", 32'(o_werr), 32'(m_werr));
      if (m_state == 0) chk("ready_in_init", 32'(o_ready), 32'd0);
      if (hold_pend) begin
        chk("hold_valid", 32'(o_valid), 32'd1);
        chk("hold_data", 32'(cur), 32'(hold_val));
        hold_pend = 1'b0;
      end
      if (o_valid && i_ready) begin
        if (q.size() == 0) chk("spurious_out", 32'(o_valid), 32'd0);
        else begin
          exp_b = q.pop_front();
          chk("pixel", 32'(cur), 32'(exp_b));
        end
      end
      if (o_valid && !i_ready) begin
        hold_pend = 1'b1;
        hold_val  = cur;
      end
    end
    if (i_reset) begin
      m_state = 0; m_cnt = 0; m_act = 1'b0; m_werr = 1'b0;
      q.delete(); hold_pend = 1'b0; m_known = 1'b1;
      return;
    end
    if (!m_known) return;
    old    = m_state;
    m_werr = i_wr && (old != 1);
    if (i_valid && o_ready) begin
      swap      = (old == 2) && i_sof;
      sel       = m_act ^ swap;
      exp_b.rgb = m_bank[sel][i_pixel];
      exp_b.sof = i_sof;
      exp_b.last = i_last;
      q.push_back(exp_b);
      if (swap) begin
        m_act   = sel;
        m_state = 1;
      end
    end
    case (old)
      0: begin
        if (m_cnt == 255) begin
          for (int j = 0; j < 256; j++) begin
            m_bank[0][j] = {3{8'(j)}};
            m_bank[1][j] = {3{8'(j)}};
          end
          m_state = 1;
        end
        m_cnt++;
      end
      1: begin
        if (i_wr) m_bank[!m_act][i_waddr] = i_wdata;
        if (i_commit) m_state = 2;
      end
      default: ;
    endcase
  endtask

  task automatic cyc(output logic acc);
    @(negedge i_clk);
    acc = i_valid && o_ready;
    sample();
    @(posedge i_clk);
    #1;
  endtask

  task automatic tick();
    logic a;
    cyc(a);
  endtask

  task automatic send(input logic [7:0] pix, input logic sof, input logic last);
    logic acc;
    int   n;
    i_valid = 1'b1; i_pixel = pix; i_sof = sof; i_last = last;
    n = 0;
    do begin
      cyc(acc);
      n++;
    end while (!acc && n < 50);
    if (!acc) chk("accept_timeout", 32'(acc), 32'd1);
    i_valid = 1'b0; i_sof = 1'b0; i_last = 1'b0;
  endtask

  task automatic drain();
    i_valid = 1'b0;
    i_ready = 1'b1;
    repeat (4) tick();
  endtask

  task automatic wait_init(input string tag);
    int n;
    n = 0;
    while (o_busy && n < 1000) begin
      n++;
      tick();
    end
    chk(tag, 32'(n), 32'd256);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    int   idx, k;
    m_known = 1'b0; hold_pend = 1'b0; m_werr = 1'b0; m_state = 0; m_cnt = 0; m_act = 1'b0;
    i_reset = 1'b1; i_wr = 1'b0; i_commit = 1'b0; i_valid = 1'b0; i_sof = 1'b0; i_last = 1'b0;
    i_ready = 1'b1; i_waddr = '0; i_pixel = '0; i_wdata = '0;
    tick(); tick();
    i_reset = 1'b0;
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd1);
    chk("rst_pending", 32'(o_pending), 32'd0);
    chk("rst_werr", 32'(o_werr), 32'd0);
    chk("rst_ready", 32'(o_ready), 32'd0);
    chk("rst_rgb", 32'({o_r, o_g, o_b}), 32'd0);
    chk("rst_sof_last", 32'({o_sof, o_last}), 32'd0);
    wait_init("init_len");

    // Gray lookup and two-cycle latency.
    send(8'h40, 1'b0, 1'b0);
    chk("lat1_valid", 32'(o_valid), 32'd0);
    tick();
    chk("lat2_valid", 32'(o_valid), 32'd1);
    chk("lat2_rgb", 32'({o_r, o_g, o_b}), 32'h404040);
    drain();

    // Back-bank write, commit, swap on the sof beat.
    i_wr = 1'b1; i_waddr = 8'h10; i_wdata = 24'hff0026;
    tick();
    i_wr = 1'b0; i_commit = 1'b1;
    tick();
    i_commit = 1'b0;
    chk("pend_after_commit", 32'(o_pending), 32'd1);
    send(8'h10, 1'b0, 1'b0);
    send(8'h10, 1'b0, 1'b0);
    send(8'h10, 1'b0, 1'b0);
    chk("pend_before_sof", 32'(o_pending), 32'd1);
    send(8'h10, 1'b1, 1'b0);
    chk("pend_after_sof", 32'(o_pending), 32'd0);
    send(8'h10, 1'b0, 1'b0);
    send(8'h10, 1'b0, 1'b1);
    drain();
    chk("swapped_rgb", 32'({o_r, o_g, o_b}), 32'hff0026);

    // Write during PEND is dropped with a one-cycle error pulse.
    i_commit = 1'b1;
    tick();
    i_commit = 1'b0;
    i_wr = 1'b1; i_waddr = 8'h20; i_wdata = 24'h123456;
    tick();
    i_wr = 1'b0;
    chk("werr_pulse", 32'(o_werr), 32'd1);
    tick();
    chk("werr_clear", 32'(o_werr), 32'd0);
    send(8'h20, 1'b1, 1'b0);
    send(8'h10, 1'b0, 1'b0);
    send(8'h20, 1'b0, 1'b1);
    drain();
    chk("dropped_entry_rgb", 32'({o_r, o_g, o_b}), 32'h202020);

    // Back-pressure with i_ready pattern 1,0,0,1.
    idx = 0; k = 0;
    while (idx < 12 && k < 200) begin
      i_ready = (k % 4 == 0) || (k % 4 == 3);
      i_valid = 1'b1; i_pixel = 8'(8'h80 + idx); i_sof = (idx == 0); i_last = (idx % 4 == 3);
      cyc(acc);
      if (acc) idx++;
      k++;
    end
    chk("stall_sent", 32'(idx), 32'd12);
    i_sof = 1'b0; i_last = 1'b0;
    drain();
    chk("stall_q_empty", 32'(q.size()), 32'd0);

    // Commit coinciding with an accepted sof beat: swap waits for the next sof.
    i_commit = 1'b1;
    send(8'h10, 1'b1, 1'b0);
    i_commit = 1'b0;
    chk("pend_coincident", 32'(o_pending), 32'd1);
    send(8'h10, 1'b0, 1'b0);
    send(8'h10, 1'b0, 1'b1);
    drain();
    chk("no_swap_rgb", 32'({o_r, o_g, o_b}), 32'h101010);
    send(8'h10, 1'b1, 1'b0);
    drain();
    chk("next_sof_rgb", 32'({o_r, o_g, o_b}), 32'hff0026);
    chk("pend_done", 32'(o_pending), 32'd0);

    // Reset mid-frame with a valid output.
    send(8'h30, 1'b1, 1'b0);
    send(8'h31, 1'b0, 1'b0);
    send(8'h32, 1'b0, 1'b0);
    chk("pre_reset_valid", 32'(o_valid), 32'd1);
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    chk("mid_rst_valid", 32'(o_valid), 32'd0);
    chk("mid_rst_busy", 32'(o_busy), 32'd1);
    wait_init("reinit_len");
    send(8'h10, 1'b0, 1'b0);
    drain();
    chk("reinit_bank0_rgb", 32'({o_r, o_g, o_b}), 32'h101010);
    i_commit = 1'b1;
    tick();
    i_commit = 1'b0;
    send(8'h10, 1'b1, 1'b0);
    drain();
    chk("reinit_bank1_rgb", 32'({o_r, o_g, o_b}), 32'h101010);
    chk("final_q_empty", 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cmap_ctrl.md
Name: cmap_ctrl

Overview:
- Programmable, double-buffered false-color map controller for the spectrogram display path.
- Sits between the FFT log-magnitude pixel stream and the video output; replaces fixed colormap tables with a RAM that software reloads while pixels flow.
- Writes go to the back bank. A committed bank swaps in only at a frame start, so no frame shows a mix of two maps.
- After reset, fills both banks with a grayscale ramp.

Parameters:
- PW, 8, pixel index width; table depth is 2^PW.
- CW, 8, width of each color component.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous active-high reset
- i_wr  in  1  table write strobe
- i_waddr  in  PW  table entry index
- i_wdata  in  3*CW  {r,g,b} entry
- i_commit  in  1  request back/active bank swap
- o_werr  out  1  one-cycle pulse: write dropped
- o_busy  out  1  init fill in progress
- o_pending  out  1  commit accepted, swap not yet done
- i_valid  in  1  input pixel valid
- o_ready  out  1  input pixel accepted when i_valid && o_ready
- i_pixel  in  PW  pixel index
- i_sof  in  1  first pixel of frame
- i_last  in  1  last pixel of line
- o_valid  out  1  output valid
- i_ready  in  1  downstream ready
- o_r, o_g, o_b  out  CW each  mapped color
- o_sof, o_last  out  1 each  delayed i_sof, i_last

Behaviour:
- Reset is synchronous on i_clk. Values after reset:
  - o_valid=0, o_pending=0, o_werr=0, o_busy=1, o_ready=0.
  - active bank=0; FSM=INIT; init counter=0.
  - o_r/o_g/o_b/o_sof/o_last=0.
  - Reset mid-frame or mid-init discards both pipeline stages and restarts INIT.
- FSM states: INIT, RUN, PEND.
  - INIT: each cycle writes entry cnt={cnt,cnt,cnt} (zero-extended/truncated to CW) into both banks, then cnt++. After entry 2^PW-1 -> RUN. INIT lasts exactly 2^PW cycles.
  - RUN: i_commit -> PEND.
  - PEND: the first accepted beat with i_sof=1 toggles the active bank and returns to RUN. That beat and all later beats use the new bank.
  - A commit in the same cycle as an accepted sof beat in RUN does not swap on that beat; the swap waits for the next sof.
  - i_commit in PEND or INIT is ignored.
- Writes:
  - Accepted only in RUN, and land in the back bank (!active).
  - i_wr in INIT or PEND is dropped and o_werr pulses high for the following cycle.
  - A write and a commit in the same cycle in RUN: the write lands, then the state moves to PEND.
- Pixel pipeline, 2 stages:
  - Stage 1 is the registered RAM read; stage 2 is the output register.
  - ce = !o_busy && (!o_valid || i_ready). o_ready = ce (combinational).
  - All stage registers and the RAM read enable advance only on ce. When i_ready=0 with o_valid=1, outputs hold stable.
  - Latency: an accepted beat appears on the outputs 2 cycles later if there is no stall.
  - Full throughput: one pixel per clock when i_ready=1 continuously.
  - The bank is selected per beat at acceptance. An in-flight beat is unaffected by a later swap.
- o_sof/o_last travel with their pixel. Table contents are undefined before INIT completes, but are never visible because o_ready=0 during INIT.
- o_pending = (state==PEND). o_busy = (state==INIT).

Decomposition:
- Package cmap_pkg:
  - PW/CW defaults.
  - state encoding (INIT/RUN/PEND).
  - RGB pack/unpack ordering: r in the MSBs.
- Sub-module cmap_bank_ram:
  - simple dual-port 2*2^PW x 3*CW RAM.
  - address = {bank, index}.
  - one write port, one registered read port with read enable.
  - INIT drives the write port twice per entry via a bank-toggle bit, or through a 2-bank write-enable mask (implementer's choice; externally INIT is 2^PW cycles).

Test Plan:
- Reset, then count cycles -> o_busy=1 for exactly 256 cycles, then 0. Pixel 0x40 in -> o_r=o_g=o_b=0x40, o_valid 2 cycles after acceptance.
- Write entry 0x10={0xff,0x00,0x26} in RUN, then i_commit, then stream with i_sof on beat 3 -> beats before sof map 0x10 to gray 0x10; beats from sof onward map to {ff,00,26}; o_pending 1 until the sof beat, then 0.
- i_wr while o_pending=1 -> o_werr pulses for 1 cycle; after the swap, that entry still holds its old value.
- Continuous stream with i_ready toggling 1,0,0,1 -> no pixel lost or duplicated; outputs held during the low cycles; order preserved; o_last aligned.
- Commit in the same cycle as an accepted sof beat -> no swap on that frame; swap occurs at the next sof.
- Assert i_reset for 1 cycle mid-frame with o_valid=1 -> next cycle o_valid=0, o_busy=1, active bank=0; after 256 cycles a gray map is restored.
